// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for the pipeline control slice.
// Contents: instruction codes, status codes, the "no register" ID,
// the pipe_ctrl state enum, and a saturating-increment helper.
package y86_pkg;

  // Instruction codes (icode field)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register ID meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Run/halt controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } ctrl_state_t;

  // Increment when enabled, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational hazard classification for the
// five-stage Y86-64 pipeline.
// Inputs : D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
//          m_stat, W_stat
// Outputs: lu  - load/use hazard (load in E feeding a source in D)
//          ret - a RET is in D, E or M
//          mp  - jump in E was mispredicted (predicted taken, not taken)
//          exc - an exceptional status is in M or W
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       lu,
  output logic       ret,
  output logic       mp,
  output logic       exc
);

  logic e_is_load;

  assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);

  assign lu  = e_is_load && (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp  = (E_icode == I_JXX) && !e_Cnd;
  assign exc = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage Y86-64 core.
// Generates stall/bubble strobes for the F/D/E/M/W pipeline registers,
// gates condition-code updates and runs an IDLE/RUN/HALT controller that
// freezes the pipe once an exceptional status reaches writeback.
// Inputs : clk, rst (async, active high), start, D_icode, d_srcA, d_srcB,
//          E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_icode, W_stat
// Outputs: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
//          (combinational), halted, final_stat (registered),
//          cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rb_cnt (performance counters)
// Config : define PIPE_CTRL_PERF_EN to implement the saturating counters;
//          otherwise the counter ports are tied to zero.
module pipe_ctrl
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [3:0]  M_icode,
  input  logic [2:0]  m_stat,
  input  logic [3:0]  W_icode,
  input  logic [2:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic        set_cc,
  output logic        halted,
  output logic [2:0]  final_stat,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt,
  output logic [31:0] lu_cnt,
  output logic [31:0] mp_cnt,
  output logic [31:0] rb_cnt
);

  ctrl_state_t state;
  logic lu, ret, mp, exc;

  hazard_detect u_hazard (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .lu      (lu),
    .ret     (ret),
    .mp      (mp),
    .exc     (exc)
  );

  // Run/halt controller; halted and final_stat are registered alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      halted     <= 1'b0;
      final_stat <= STAT_AOK;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_RUN;
        S_RUN: begin
          if (W_stat != STAT_AOK) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            final_stat <= W_stat;
          end
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pipeline register controls. In RUN, lu gates the ret term out of
  // D_bubble, so D_stall and D_bubble are mutually exclusive.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    case (state)
      S_IDLE: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      S_RUN: begin
        F_stall  = lu || ret;
        D_stall  = lu;
        D_bubble = (mp || (!lu && ret)) && !lu;
        E_bubble = mp || lu;
        M_bubble = exc;
        W_stall  = (W_stat != STAT_AOK);
        set_cc   = (E_icode == I_OPQ) && !exc;
      end
      S_HALT: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, ret_cnt_q, lu_cnt_q, mp_cnt_q, rb_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
      lu_cnt_q  <= '0;
      mp_cnt_q  <= '0;
      rb_cnt_q  <= '0;
    end else if (state == S_RUN) begin
      cyc_cnt_q <= sat_inc(cyc_cnt_q, 1'b1);
      ret_cnt_q <= sat_inc(ret_cnt_q, (W_stat == STAT_AOK) && (W_icode != I_NOP));
      lu_cnt_q  <= sat_inc(lu_cnt_q, lu);
      mp_cnt_q  <= sat_inc(mp_cnt_q, mp);
      rb_cnt_q  <= sat_inc(rb_cnt_q, ret && !lu);
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
  assign lu_cnt  = lu_cnt_q;
  assign mp_cnt  = mp_cnt_q;
  assign rb_cnt  = rb_cnt_q;
`else
  // W_icode only feeds the retirement counter.
  logic unused_w_icode;
  assign unused_w_icode = ^W_icode;

  assign cyc_cnt = '0;
  assign ret_cnt = '0;
  assign lu_cnt  = '0;
  assign mp_cnt  = '0;
  assign rb_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized self-checking bench for pipe_ctrl with a
// behavioural model of the run/halt controller, hazard rules and counters.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic        halted;
  logic [2:0]  final_stat;
  logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rb_cnt;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat),
    .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .halted(halted), .final_stat(final_stat),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt),
    .mp_cnt(mp_cnt), .rb_cnt(rb_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = idle, 1 = running, 2 = halted
  int             mode;
  logic           m_halted;
  logic [2:0]     m_final;
  longint unsigned mc [5];   // cyc, ret, lu, mp, rb
  bit             chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  endfunction

  function automatic bit is_lu();
    return (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'd15 &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction
  function automatic bit is_ret();
    return D_icode == 4'd9 || E_icode == 4'd9 || M_icode == 4'd9;
  endfunction
  function automatic bit is_mp();
    return E_icode == 4'd7 && !e_Cnd;
  endfunction
  function automatic bit is_exc();
    return m_stat != 3'd1 || W_stat != 3'd1;
  endfunction

  // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  function automatic logic [6:0] exp_ctrl();
    bit lu, rt, mp, ex;
    lu = is_lu(); rt = is_ret(); mp = is_mp(); ex = is_exc();
    if (mode == 0) return 7'b1011100;
    if (mode == 2) return 7'b1101110;
    return {lu || rt, lu, mp || (!lu && rt), mp || lu, ex, W_stat != 3'd1,
            E_icode == 4'd6 && !ex};
  endfunction

  task automatic sat(input int i, input bit en);
    if (en && mc[i] < 64'hFFFF_FFFF) mc[i] = mc[i] + 1;
  endtask

  task automatic model_edge();
    if (rst) begin
      mode = 0; m_halted = 1'b0; m_final = 3'd1;
      for (int i = 0; i < 5; i++) mc[i] = 0;
    end else if (mode == 0) begin
      if (start) mode = 1;
    end else if (mode == 1) begin
      sat(0, 1'b1);
      sat(1, W_stat == 3'd1 && W_icode != 4'd1);
      sat(2, is_lu());
      sat(3, is_mp());
      sat(4, is_ret() && !is_lu());
      if (W_stat != 3'd1) begin
        mode = 2; m_halted = 1'b1; m_final = W_stat;
      end
    end
  endtask

  // One clock: model follows the edge, inputs may change 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic nops();
    D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1; W_icode = 4'd1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  logic [31:0] dcnt [5];
  assign dcnt[0] = cyc_cnt;
  assign dcnt[1] = ret_cnt;
  assign dcnt[2] = lu_cnt;
  assign dcnt[3] = mp_cnt;
  assign dcnt[4] = rb_cnt;

  longint unsigned lu_before;

  initial begin
    rst = 1'b1; start = 1'b1; nops();
    mode = 0; m_halted = 1'b0; m_final = 3'd1;
    for (int i = 0; i < 5; i++) mc[i] = 0;

    // Compare process: every negedge, all outputs against the model.
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("ctrl", {25'd0, ctrl_vec()}, {25'd0, exp_ctrl()});
          chk("halted", {31'd0, halted}, {31'd0, m_halted});
          chk("final_stat", {29'd0, final_stat}, {29'd0, m_final});
          for (int i = 0; i < 5; i++) begin
`ifdef PIPE_CTRL_PERF_EN
            chk($sformatf("cnt%0d", i), dcnt[i], mc[i][31:0]);
`else
            chk($sformatf("cnt%0d", i), dcnt[i], 32'd0);
`endif
          end
        end
      end
    join_none

    chk_en = 1'b1;
    // start held during reset must be ignored
    cycle(); cycle();
    rst = 1'b0; start = 1'b0;
    repeat (3) cycle();
    chk("idle_halted", {31'd0, halted}, 32'd0);
    chk("idle_ctrl", {25'd0, ctrl_vec()}, 32'h5C);
    chk("idle_cyc", cyc_cnt, 32'd0);

    start = 1'b1; cycle(); start = 1'b0;
    #1 chk("run_nop_ctrl", {25'd0, ctrl_vec()}, 32'd0);

    // load/use
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    #1 chk("lu_ctrl", {25'd0, ctrl_vec()}, 32'h68);
    lu_before = mc[2];
    cycle();
`ifdef PIPE_CTRL_PERF_EN
    chk("lu_cnt_inc", lu_cnt, lu_before[31:0] + 32'd1);
`endif
    nops();
    // mispredict, then correctly predicted jump
    E_icode = 4'd7; e_Cnd = 1'b0;
    #1 chk("mp_ctrl", {25'd0, ctrl_vec()}, 32'h18);
    cycle();
    e_Cnd = 1'b1;
    #1 chk("jmp_ok_ctrl", {25'd0, ctrl_vec()}, 32'd0);
    cycle(); nops();
    // ret in M, then ret combined with load/use
    M_icode = 4'd9;
    #1 chk("ret_ctrl", {25'd0, ctrl_vec()}, 32'h50);
    cycle();
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    #1 chk("ret_lu_ctrl", {25'd0, ctrl_vec()}, 32'h68);
    cycle(); nops();

    // randomized run, W_stat kept AOK so the controller stays in RUN
    for (int n = 0; n < 3000; n++) begin
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      W_icode = 4'($urandom_range(0, 11));
      d_srcA  = 4'($urandom_range(0, 15));
      d_srcB  = 4'($urandom_range(0, 15));
      E_dstM  = ($urandom_range(0, 2) == 0) ? d_srcA : 4'($urandom_range(0, 15));
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat  = 3'd1;
      cycle();
    end
    nops();

`ifdef PIPE_CTRL_PERF_EN
    force dut.cyc_cnt_q = 32'hFFFF_FFFE;
    mc[0] = 64'hFFFF_FFFE;
    #1 release dut.cyc_cnt_q;
    repeat (3) cycle();
    chk("cyc_sat", cyc_cnt, 32'hFFFF_FFFF);
`endif

    // exception in M, then halting status in W
    E_icode = 4'd6; m_stat = 3'd3;
    #1 chk("exc_ctrl", {25'd0, ctrl_vec()}, 32'h04);
    cycle(); nops();
    W_stat = 3'd2;
    #1 chk("wstall_ctrl", {25'd0, ctrl_vec()}, 32'h06);
    chk("pre_halt", {31'd0, halted}, 32'd0);
    cycle();
    chk("halted", {31'd0, halted}, 32'd1);
    chk("final_hlt", {29'd0, final_stat}, 32'd2);
    nops();
    start = 1'b1; cycle(); start = 1'b0;
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    #1 chk("halt_ctrl", {25'd0, ctrl_vec()}, 32'h6E);
    repeat (3) cycle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
